// File: rtl/fpu_normalize_round_pkg.sv
// Shared definitions for the 8087 post-adder normalize/round stage:
// rounding-control codes, exponent limits, FSM states and the rounding-increment rule.
package fpu_normalize_round_pkg;

  localparam logic [1:0] RC_RN = 2'b00;
  localparam logic [1:0] RC_RD = 2'b01;
  localparam logic [1:0] RC_RU = 2'b10;
  localparam logic [1:0] RC_RZ = 2'b11;

  localparam logic [14:0] EXP_MAX = 15'h7FFF;
  localparam logic [63:0] SIG_ONE = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_ROUND, ST_DONE} state_e;

  // Working operand: mant is {carry, int, 63 frac, G, R, S}
  typedef struct packed {
    logic        sign;
    logic [15:0] exp;
    logic [67:0] mant;
    logic [1:0]  rc;
  } work_t;

  typedef struct packed {
    logic pe;
    logic oe;
    logic ue;
    logic zero;
  } flags_t;

  function automatic logic round_inc(input logic [1:0] rc, input logic sign,
                                     input logic l, input logic g,
                                     input logic r, input logic s);
    logic inc;
    unique case (rc)
      RC_RN:   inc = g & (r | s | l);
      RC_RD:   inc = sign & (g | r | s);
      RC_RU:   inc = ~sign & (g | r | s);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fpu_normalize_round_if.sv
// Operand/result handshake bundle for the normalize/round stage.
// master drives operands and out_ready; slave is the stage itself.
interface fpu_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [15:0] in_exp;
  logic [67:0] in_mant;
  logic [1:0]  rc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] result;
  logic        flag_pe;
  logic        flag_oe;
  logic        flag_ue;
  logic        flag_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, rc, flush, out_ready,
    input  in_ready, out_valid, result, flag_pe, flag_oe, flag_ue, flag_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, rc, flush, out_ready,
    output in_ready, out_valid, result, flag_pe, flag_oe, flag_ue, flag_zero
  );
endinterface

// File: rtl/fpu_normalize_round_lzc.sv
// Combinational 67-bit leading-zero counter; returns 67 for an all-zero vector.
module fpu_normalize_round_lzc (
  input  logic [66:0] vec,
  output logic [6:0]  cnt
);
  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = 7'd67;
    for (int i = 0; i < 67; i++) begin
      if (vec[i]) cnt = 7'(66 - i);
    end
  end
endmodule

// File: rtl/fpu_normalize_round.sv
// Post-adder normalize and round: carry right-shift or bounded iterative left-shift,
// then 8087 RC rounding to an 80-bit extended result with PE/OE/UE/zero flags.
module fpu_normalize_round
  import fpu_normalize_round_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input logic               clk,
  input logic               rst_n,
  fpu_normalize_round_if.slave bus
);

  localparam logic [6:0] STEP7 = 7'(SHIFT_STEP);

  state_e      state_q, state_d;
  work_t       work_q, work_d;
  logic        out_valid_q, out_valid_d;
  logic [79:0] result_q, result_d;
  flags_t      flags_q, flags_d;

  logic [6:0]  lzc;
  logic [15:0] exp_m1;
  logic [6:0]  k;
  logic [67:0] mant_shl;
  logic [15:0] exp_shl;

  fpu_normalize_round_lzc u_lzc (
    .vec (work_q.mant[66:0]),
    .cnt (lzc)
  );

  // Left-shift distance: never past the leading one, the step limit, or exponent 1.
  always_comb begin
    exp_m1 = work_q.exp - 16'd1;
    k      = (lzc < STEP7) ? lzc : STEP7;
    if (exp_m1 < {9'd0, k}) k = exp_m1[6:0];
    mant_shl = work_q.mant << k;
    exp_shl  = work_q.exp - {9'd0, k};
  end

  logic        inc;
  logic [64:0] sum;
  logic [63:0] sig_r;
  logic [15:0] exp_r;
  logic        is_zero;
  logic        ovf;
  logic        to_inf;
  logic [14:0] exp_f;
  logic [79:0] rnd_res;
  flags_t      rnd_flags;

  always_comb begin
    inc     = round_inc(work_q.rc, work_q.sign, work_q.mant[3],
                        work_q.mant[2], work_q.mant[1], work_q.mant[0]);
    sum     = {1'b0, work_q.mant[66:3]} + {64'd0, inc};
    sig_r   = sum[64] ? SIG_ONE : sum[63:0];
    exp_r   = work_q.exp + {15'd0, sum[64]};
    is_zero = (sig_r == 64'd0);
    ovf     = ~is_zero & (exp_r >= {1'b0, EXP_MAX});
    to_inf  = (work_q.rc == RC_RN) | ((work_q.rc == RC_RU) & ~work_q.sign)
            | ((work_q.rc == RC_RD) & work_q.sign);
    // Exponent 1 without the integer bit is encoded as a denormal (field 0).
    exp_f   = (is_zero | ((exp_r == 16'd1) & ~sig_r[63])) ? 15'd0 : exp_r[14:0];
    rnd_res = {work_q.sign, exp_f, sig_r};
    if (ovf) begin
      rnd_res = to_inf ? {work_q.sign, EXP_MAX, SIG_ONE}
                       : {work_q.sign, EXP_MAX - 15'd1, {64{1'b1}}};
    end
    rnd_flags.pe   = (|work_q.mant[2:0]) | ovf;
    rnd_flags.oe   = ovf;
    rnd_flags.zero = is_zero;
    rnd_flags.ue   = (rnd_res[78:64] == 15'd0) & rnd_flags.pe;
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (bus.flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work_d  = '{sign: bus.in_sign, exp: bus.in_exp, mant: bus.in_mant, rc: bus.rc};
            state_d = ST_NORM;
          end
        end
        ST_NORM: begin
          if (work_q.mant[67]) begin
            work_d.mant = {1'b0, work_q.mant[67:2], work_q.mant[1] | work_q.mant[0]};
            work_d.exp  = work_q.exp + 16'd1;
            state_d     = ST_ROUND;
          end else if ((work_q.mant[66:0] == 67'd0) || work_q.mant[66] ||
                       (work_q.exp <= 16'd1)) begin
            state_d = ST_ROUND;
          end else begin
            work_d.mant = mant_shl;
            work_d.exp  = exp_shl;
            // Leave as soon as the shift lands, saving a re-check cycle.
            if (mant_shl[66] || (exp_shl <= 16'd1)) state_d = ST_ROUND;
          end
        end
        ST_ROUND: begin
          result_d    = rnd_res;
          flags_d     = rnd_flags;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_pe   = flags_q.pe;
  assign bus.flag_oe   = flags_q.oe;
  assign bus.flag_ue   = flags_q.ue;
  assign bus.flag_zero = flags_q.zero;

endmodule
